cpu_log_checker: RTL and testbench



---
 rtl/cpu_log_checker.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cpu_log_checker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_log_checker.sv
// cpu_log_checker: streaming parser/checker for CPU trace log records.
// Consumes one ASCII character per clock and recognises register-write
// records (^time@pc: $grf <= data#) and memory-write records
// (^time@pc: *addr <= data#). On the edge that samples '#', the parsed
// fields are captured; format_type and error_code then pulse for one cycle.
module cpu_log_checker #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned HEX_DIGITS  = 8,
    parameter bit          ALLOW_UPPER = 1'b0,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_6ffc,
    parameter logic [31:0] ADDR_MAX    = 32'h0000_2ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code,
    output logic [31:0] time_val,
    output logic [31:0] pc_val,
    output logic [31:0] dst_val,
    output logic [31:0] data_val
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CARET,
        S_TIME,
        S_AT,
        S_PC,
        S_COLON_SP,
        S_DOLLAR,
        S_GRF,
        S_STAR,
        S_ADDR,
        S_PRE_LT,
        S_LT,
        S_EQ_SP,
        S_DATA,
        S_ACCEPT
    } state_t;

    localparam logic [7:0] TIME_N = 8'(TIME_DIGITS);
    localparam logic [7:0] HEX_N  = 8'(HEX_DIGITS);
    localparam logic [7:0] GRF_N  = 8'd4;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [31:0] time_acc, time_n;
    logic [31:0] pc_acc, pc_n;
    logic [31:0] dst_acc, dst_n;
    logic [31:0] data_acc, data_n;
    logic        is_mem, mem_n;
    logic        capture;

    logic        is_dec;
    logic        is_lower;
    logic        is_upper;
    logic        is_hex;
    logic [3:0]  nib;
    logic [31:0] nib_ext;

    // Character classification; '0'-'9', 'a'-'f' and 'A'-'F' all carry the
    // digit value in the low nibble, offset by 9 for the letters.
    always_comb begin
        is_dec   = (char >= "0") && (char <= "9");
        is_lower = (char >= "a") && (char <= "f");
        is_upper = (char >= "A") && (char <= "F");
        is_hex   = is_dec || is_lower || (ALLOW_UPPER && is_upper);
        nib      = is_dec ? char[3:0] : (char[3:0] + 4'd9);
        nib_ext  = {28'd0, nib};
    end

    // Next-state and field accumulation; every unlisted character falls back to IDLE.
    always_comb begin
        state_n = S_IDLE;
        cnt_n   = cnt;
        time_n  = time_acc;
        pc_n    = pc_acc;
        dst_n   = dst_acc;
        data_n  = data_acc;
        mem_n   = is_mem;
        capture = 1'b0;

        if (char == "^") begin
            // Resync: a caret always starts a fresh record.
            state_n = S_CARET;
            cnt_n   = '0;
            time_n  = '0;
            pc_n    = '0;
            dst_n   = '0;
            data_n  = '0;
        end else begin
            case (state)
                S_CARET: begin
                    if (is_dec) begin
                        state_n = S_TIME;
                        cnt_n   = 8'd1;
                        time_n  = nib_ext;
                    end
                end
                S_TIME: begin
                    if (is_dec) begin
                        if (cnt != TIME_N) begin
                            state_n = S_TIME;
                            cnt_n   = cnt + 8'd1;
                            time_n  = time_acc * 32'd10 + nib_ext;
                        end
                    end else if (char == "@") begin
                        state_n = S_AT;
                    end
                end
                S_AT: begin
                    if (is_hex) begin
                        state_n = S_PC;
                        cnt_n   = 8'd1;
                        pc_n    = nib_ext;
                    end
                end
                S_PC: begin
                    if (is_hex) begin
                        if (cnt != HEX_N) begin
                            state_n = S_PC;
                            cnt_n   = cnt + 8'd1;
                            pc_n    = {pc_acc[27:0], nib};
                        end
                    end else if ((char == ":") && (cnt == HEX_N)) begin
                        state_n = S_COLON_SP;
                    end
                end
                S_COLON_SP: begin
                    if (char == " ") begin
                        state_n = S_COLON_SP;
                    end else if (char == "$") begin
                        state_n = S_DOLLAR;
                        mem_n   = 1'b0;
                    end else if (char == "*") begin
                        state_n = S_STAR;
                        mem_n   = 1'b1;
                    end
                end
                S_DOLLAR: begin
                    if (is_dec) begin
                        state_n = S_GRF;
                        cnt_n   = 8'd1;
                        dst_n   = nib_ext;
                    end
                end
                S_GRF: begin
                    if (is_dec) begin
                        if (cnt != GRF_N) begin
                            state_n = S_GRF;
                            cnt_n   = cnt + 8'd1;
                            dst_n   = dst_acc * 32'd10 + nib_ext;
                        end
                    end else if (char == " ") begin
                        state_n = S_PRE_LT;
                    end else if (char == "<") begin
                        state_n = S_LT;
                    end
                end
                S_STAR: begin
                    if (is_hex) begin
                        state_n = S_ADDR;
                        cnt_n   = 8'd1;
                        dst_n   = nib_ext;
                    end
                end
                S_ADDR: begin
                    if (is_hex) begin
                        if (cnt != HEX_N) begin
                            state_n = S_ADDR;
                            cnt_n   = cnt + 8'd1;
                            dst_n   = {dst_acc[27:0], nib};
                        end
                    end else if ((char == " ") && (cnt == HEX_N)) begin
                        state_n = S_PRE_LT;
                    end else if ((char == "<") && (cnt == HEX_N)) begin
                        state_n = S_LT;
                    end
                end
                S_PRE_LT: begin
                    if (char == " ") begin
                        state_n = S_PRE_LT;
                    end else if (char == "<") begin
                        state_n = S_LT;
                    end
                end
                S_LT: begin
                    if (char == "=") begin
                        state_n = S_EQ_SP;
                    end
                end
                S_EQ_SP: begin
                    if (char == " ") begin
                        state_n = S_EQ_SP;
                    end else if (is_hex) begin
                        state_n = S_DATA;
                        cnt_n   = 8'd1;
                        data_n  = nib_ext;
                    end
                end
                S_DATA: begin
                    if (is_hex) begin
                        if (cnt != HEX_N) begin
                            state_n = S_DATA;
                            cnt_n   = cnt + 8'd1;
                            data_n  = {data_acc[27:0], nib};
                        end
                    end else if ((char == "#") && (cnt == HEX_N)) begin
                        state_n = S_ACCEPT;
                        capture = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State, accumulators and captured record fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            time_acc <= '0;
            pc_acc   <= '0;
            dst_acc  <= '0;
            data_acc <= '0;
            is_mem   <= 1'b0;
            time_val <= '0;
            pc_val   <= '0;
            dst_val  <= '0;
            data_val <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            time_acc <= time_n;
            pc_acc   <= pc_n;
            dst_acc  <= dst_n;
            data_acc <= data_n;
            is_mem   <= mem_n;
            if (capture) begin
                time_val <= time_acc;
                pc_val   <= pc_acc;
                dst_val  <= dst_acc;
                data_val <= data_acc;
            end
        end
    end

    // Record type and semantic error flags, asserted only while in ACCEPT.
    always_comb begin
        format_type = '0;
        error_code  = '0;
        if (state == S_ACCEPT) begin
            format_type   = is_mem ? 2'b10 : 2'b01;
            error_code[0] = time_val[0];
            error_code[1] = (pc_val < PC_MIN) || (pc_val > PC_MAX) || (pc_val[1:0] != 2'b00);
            error_code[2] = is_mem && ((dst_val > ADDR_MAX) || (dst_val[1:0] != 2'b00));
            error_code[3] = !is_mem && (dst_val > 32'd31);
        end
    end

endmodule

// File: tb/tb_cpu_log_checker.sv
// Bench for cpu_log_checker: two instances (lower-case only / upper allowed)
// share one character stream; a string-level grammar model predicts outputs.
module tb_cpu_log_checker;

    localparam int unsigned TIME_DIGITS = 4;
    localparam int unsigned HEX_DIGITS  = 8;
    localparam logic [31:0] PC_MIN      = 32'h0000_3000;
    localparam logic [31:0] PC_MAX      = 32'h0000_6ffc;
    localparam logic [31:0] ADDR_MAX    = 32'h0000_2ffc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ch = 8'h00;

    logic [1:0]  fmt  [2];
    logic [3:0]  err  [2];
    logic [31:0] tval [2];
    logic [31:0] pval [2];
    logic [31:0] dval [2];
    logic [31:0] wval [2];

    int checks = 0;
    int errors = 0;
    int pulses0 = 0;

    always #5 clk = ~clk;

    cpu_log_checker #(
        .TIME_DIGITS(TIME_DIGITS), .HEX_DIGITS(HEX_DIGITS), .ALLOW_UPPER(1'b0),
        .PC_MIN(PC_MIN), .PC_MAX(PC_MAX), .ADDR_MAX(ADDR_MAX)
    ) u_lo (
        .clk(clk), .reset(reset), .char(ch),
        .format_type(fmt[0]), .error_code(err[0]),
        .time_val(tval[0]), .pc_val(pval[0]), .dst_val(dval[0]), .data_val(wval[0])
    );

    cpu_log_checker #(
        .TIME_DIGITS(TIME_DIGITS), .HEX_DIGITS(HEX_DIGITS), .ALLOW_UPPER(1'b1),
        .PC_MIN(PC_MIN), .PC_MAX(PC_MAX), .ADDR_MAX(ADDR_MAX)
    ) u_up (
        .clk(clk), .reset(reset), .char(ch),
        .format_type(fmt[1]), .error_code(err[1]),
        .time_val(tval[1]), .pc_val(pval[1]), .dst_val(dval[1]), .data_val(wval[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- grammar model ----------------
    function automatic bit is_dig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit is_hx(input logic [7:0] c, input bit up);
        return is_dig(c) || ((c >= 8'h61) && (c <= 8'h66)) || (up && (c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic [3:0] hv(input logic [7:0] c);
        if (is_dig(c)) return 4'(c - 8'h30);
        if (c >= 8'h61) return 4'(c - 8'h61 + 8'd10);
        return 4'(c - 8'h41 + 8'd10);
    endfunction

    function automatic logic [7:0] at(input string s, input int i);
        if (i < s.len()) return s[i];
        return 8'h00;
    endfunction

    function automatic int rd_num(input string s, input int i0, input bit hex, input bit up,
                                  output logic [31:0] v, output int n);
        int i = i0;
        logic [7:0] c;
        v = 0;
        n = 0;
        while (i < s.len()) begin
            c = s[i];
            if (hex ? is_hx(c, up) : is_dig(c)) begin
                v = hex ? ((v << 4) | {28'd0, hv(c)}) : (v * 10 + {28'd0, hv(c)});
                n++;
                i++;
            end else begin
                break;
            end
        end
        return i;
    endfunction

    function automatic int skip_sp(input string s, input int i0);
        int i = i0;
        while (i < s.len() && s[i] == " ") i++;
        return i;
    endfunction

    function automatic void parse(input string s, input bit up, output bit ok,
                                  output logic [1:0] ty, output logic [31:0] t,
                                  output logic [31:0] pc, output logic [31:0] dst,
                                  output logic [31:0] dat);
        int i;
        int n;
        ok = 0; ty = 0; t = 0; pc = 0; dst = 0; dat = 0;
        i = rd_num(s, 1, 1'b0, up, t, n);
        if (n < 1 || n > int'(TIME_DIGITS)) return;
        if (at(s, i) != "@") return;
        i = rd_num(s, i + 1, 1'b1, up, pc, n);
        if (n != int'(HEX_DIGITS)) return;
        if (at(s, i) != ":") return;
        i = skip_sp(s, i + 1);
        if (at(s, i) == "$") begin
            ty = 2'b01;
            i = rd_num(s, i + 1, 1'b0, up, dst, n);
            if (n < 1 || n > 4) return;
        end else if (at(s, i) == "*") begin
            ty = 2'b10;
            i = rd_num(s, i + 1, 1'b1, up, dst, n);
            if (n != int'(HEX_DIGITS)) return;
        end else begin
            return;
        end
        i = skip_sp(s, i);
        if (at(s, i) != "<") return;
        if (at(s, i + 1) != "=") return;
        i = skip_sp(s, i + 2);
        i = rd_num(s, i, 1'b1, up, dat, n);
        if (n != int'(HEX_DIGITS)) return;
        if (at(s, i) != "#" || i != s.len() - 1) return;
        ok = 1;
    endfunction

    string       rec_buf = "";
    bit          mvalid = 0;
    logic [1:0]  e_fmt  [2];
    logic [3:0]  e_err  [2];
    logic [31:0] e_time [2];
    logic [31:0] e_pc   [2];
    logic [31:0] e_dst  [2];
    logic [31:0] e_dat  [2];

    // Model: collect the text since the last '^'; judge the whole record at '#'.
    always @(posedge clk) begin
        bit ok;
        logic [1:0] ty;
        logic [31:0] t, pc, dst, dat;
        if (reset) begin
            rec_buf = "";
            mvalid = 1;
            for (int k = 0; k < 2; k++) begin
                e_fmt[k] = 0; e_err[k] = 0; e_time[k] = 0;
                e_pc[k] = 0; e_dst[k] = 0; e_dat[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_fmt[k] = 0;
                e_err[k] = 0;
            end
            if (ch == "^") begin
                rec_buf = "^";
            end else if (rec_buf.len() > 0) begin
                rec_buf = {rec_buf, " "};
                rec_buf.putc(rec_buf.len() - 1, ch);
                if (ch == "#") begin
                    for (int k = 0; k < 2; k++) begin
                        parse(rec_buf, k == 1, ok, ty, t, pc, dst, dat);
                        if (ok) begin
                            e_fmt[k] = ty;
                            e_time[k] = t; e_pc[k] = pc; e_dst[k] = dst; e_dat[k] = dat;
                            e_err[k][0] = (t % 2) == 1;
                            e_err[k][1] = (pc < PC_MIN) || (pc > PC_MAX) || (pc % 4 != 0);
                            e_err[k][2] = (ty == 2'b10) && ((dst > ADDR_MAX) || (dst % 4 != 0));
                            e_err[k][3] = (ty == 2'b01) && (dst > 31);
                        end
                    end
                    rec_buf = "";
                end
            end
        end
    end

    // Compare every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                chk(k == 0 ? "lo.format_type" : "up.format_type", {30'd0, fmt[k]}, {30'd0, e_fmt[k]});
                chk(k == 0 ? "lo.error_code" : "up.error_code", {28'd0, err[k]}, {28'd0, e_err[k]});
                chk(k == 0 ? "lo.time_val" : "up.time_val", tval[k], e_time[k]);
                chk(k == 0 ? "lo.pc_val" : "up.pc_val", pval[k], e_pc[k]);
                chk(k == 0 ? "lo.dst_val" : "up.dst_val", dval[k], e_dst[k]);
                chk(k == 0 ? "lo.data_val" : "up.data_val", wval[k], e_dat[k]);
            end
            if (fmt[0] != 2'b00) pulses0++;
        end
    end

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1 ch = s[i];
        end
    endtask

    // Let the final character be sampled, then stop at the ACCEPT-cycle negedge.
    task automatic settle();
        @(posedge clk);
        #1 ch = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        ch = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fmt", {30'd0, fmt[0]}, 32'd0);
        chk("rst_err", {28'd0, err[0]}, 32'd0);
        chk("rst_time", tval[0], 32'd0);
        chk("rst_data", wval[0], 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        send("^10@00003000: $1 <= 0000abcd#");
        settle();
        chk("r1_fmt", {30'd0, fmt[0]}, 32'd1);
        chk("r1_err", {28'd0, err[0]}, 32'd0);
        chk("r1_time", tval[0], 32'd10);
        chk("r1_pc", pval[0], 32'h3000);
        chk("r1_dst", dval[0], 32'd1);
        chk("r1_data", wval[0], 32'h0000abcd);
        chk("r1_model_time", e_time[0], 32'd10);
        @(negedge clk);
        chk("r1_fmt_clears", {30'd0, fmt[0]}, 32'd0);

        send("^7@00003002: *00003000 <= 12345678#");
        settle();
        chk("r2_fmt", {30'd0, fmt[0]}, 32'd2);
        chk("r2_err", {28'd0, err[0]}, 32'h7);
        chk("r2_dst", dval[0], 32'h3000);
        chk("r2_data", wval[0], 32'h12345678);
        chk("r2_model_err", {28'd0, e_err[0]}, 32'h7);

        send("^12@00003004:   $40   <=   ffffffff#");
        settle();
        chk("r3_fmt", {30'd0, fmt[0]}, 32'd1);
        chk("r3_err", {28'd0, err[0]}, 32'h8);
        chk("r3_dst", dval[0], 32'd40);

        send("^12345@00003000: $1 <= 0000abcd#");
        settle();
        chk("bad_time_fmt", {30'd0, fmt[0]}, 32'd0);
        send("^10@0003000: $1 <= 0000abcd#");
        settle();
        chk("bad_pc_fmt", {30'd0, fmt[0]}, 32'd0);
        send("^10@00003000: $12345 <= 0000abcd#");
        settle();
        chk("bad_grf_fmt", {30'd0, fmt[0]}, 32'd0);
        send("^10@00003000: $1 < = 0000abcd#");
        settle();
        chk("bad_lt_fmt", {30'd0, fmt[0]}, 32'd0);
        send("^10@00003000: *000030000 <= 0000abcd#");
        settle();
        chk("bad_addr_fmt", {30'd0, fmt[0]}, 32'd0);

        send("^10@00003000: $1 <= 0000ABCD#");
        settle();
        chk("upper_lo_fmt", {30'd0, fmt[0]}, 32'd0);
        chk("upper_up_fmt", {30'd0, fmt[1]}, 32'd1);
        chk("upper_up_data", wval[1], 32'h0000abcd);

        send("^12@000^4@00003000:*00000000<=00000000#");
        settle();
        chk("resync_fmt", {30'd0, fmt[0]}, 32'd2);
        chk("resync_err", {28'd0, err[0]}, 32'd0);
        chk("resync_time", tval[0], 32'd4);

        repeat (2) @(negedge clk);
        p0 = pulses0;
        send("^12@000^4@00003000:*00000000<=00000000#");
        send("^20@00003008: $31 <= 00000001#");
        settle();
        chk("b2b_fmt", {30'd0, fmt[0]}, 32'd1);
        chk("b2b_err", {28'd0, err[0]}, 32'd0);
        chk("b2b_dst", dval[0], 32'd31);
        repeat (2) @(negedge clk);
        chk("b2b_pulses", pulses0 - p0, 32'd2);

        p0 = pulses0;
        send("^12@0000");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_time", tval[0], 32'd0);
        chk("mid_rst_dst", dval[0], 32'd0);
        send("3000: $1 <= 00000001#");
        settle();
        chk("mid_rst_fmt", {30'd0, fmt[0]}, 32'd0);
        chk("mid_rst_data", wval[0], 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_pulses", pulses0 - p0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
